vsq_psum_accumulator: RTL
=========================

// Module: vsq_psum_accumulator
// PURPOSE
//  Downstream stage of the VSQ scaling stage. Consumes the stream of scaled 24-bit partial sums.
//  Accumulates NUM_VEC vectors (or fewer, if terminated by in_last) into one wide signed result per output tile.
//  Presents each result on a valid/ready output port for the writeback stage.
//  Applies backpressure upstream while a finished result is waiting.
// PARAMETERS
//  PSUM_W   24  width of incoming partial sum, two's complement
//  ACC_W    32  accumulator/result width, signed; must be >= PSUM_W
//  NUM_VEC  16  beats per tile before automatic close; must be >= 1
//  CNT_W    $clog2(NUM_VEC+1)  width of the beat counter and out_cnt (derived, not overridden)
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       partial sum beat valid
//  in_ready   out  1       stage can accept a beat
//  in_psum    in   PSUM_W  signed scaled partial sum
//  in_last    in   1       beat closes the tile early
//  out_valid  out  1       tile result valid
//  out_ready  in   1       consumer accepts result
//  out_acc    out  ACC_W   accumulated signed result
//  out_cnt    out  CNT_W   number of beats in the tile
//  out_sat    out  1       saturation occurred in this tile (sticky per tile)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge) returns the block to IDLE.
//    - Clears: acc=0, count=0, out_valid=0, out_acc=0, out_cnt=0, out_sat=0.
//    - in_ready=0 while rst is high.
//    - rst overrides every other input, including mid-tile and in OUT; partial tile data is discarded.
//  - States:
//    - IDLE: in_ready=1.
//    - ACC: in_ready=1.
//    - OUT: in_ready=0, out_valid=1.
//  - A beat is accepted when in_valid && in_ready.
//    - acc_next = (count==0 ? 0 : acc) + sign_extend(in_psum).
//    - count_next = count + 1.
//  - IDLE -> ACC on an accepted beat that does not close the tile.
//  - Tile close: an accepted beat with in_last=1 OR count_next==NUM_VEC. The next state is OUT.
//    - out_acc, out_cnt and out_sat are registered on that same edge.
//    - out_valid=1 on the cycle after the closing beat (latency 1).
//  - NUM_VEC=1: every beat closes a tile (IDLE -> OUT directly).
//  - OUT: out_acc, out_cnt and out_sat are held stable while out_valid && !out_ready.
//  - OUT -> IDLE on out_valid && out_ready.
//    - out_valid=0 and in_ready=1 on the next cycle.
//    - acc and count cleared; no beat is accepted in the handshake cycle.
//  - in_valid with in_ready=0 is ignored; upstream holds the data.
//  - Signed add is performed at ACC_W+1 bits; overflow is detected from that sum.
// CONFIGURATION
//  - `VSQ_ACC_SAT_EN defined:
//    - On overflow, acc clamps to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)).
//    - out_sat is set for the rest of the tile.
//    - Later beats add to the clamped value.
//  - Not defined:
//    - Plain two's-complement wrap at ACC_W bits.
//    - out_sat is tied to 0.
// TESTING
//  1. NUM_VEC=4, out_ready=1, beats 10,20,30,40 -> out_acc=100, out_cnt=4, out_valid 1 cycle after 4th beat, out_sat=0.
//  2. Result pending, out_ready=0 for 5 cycles, in_valid=1 -> out_acc/out_cnt stable, in_ready=0, no beat accepted; out_ready=1 -> IDLE next cycle.
//  3. NUM_VEC=4, beats 5 then -7 with in_last=1 -> out_acc=32'hFFFFFFFE, out_cnt=2.
//  4. ACC_W=26, NUM_VEC=16, 16 beats of 24'h7FFFFF -> with `VSQ_ACC_SAT_EN: out_acc=26'h1FFFFFF, out_sat=1; without: out_acc=26'h3FFFFF0, out_sat=0.
//  5. NUM_VEC=4, 2 beats of 9, rst for 1 cycle, then beats 1,1,1,1 -> out_acc=4, out_cnt=4.
//  6. out_ready held 1, in_valid held 1 over two tiles -> one idle cycle between tiles; second tile's first beat accepted the cycle after the handshake, and its result excludes first-tile data.

Source files
------------

// File: rtl/vsq_psum_accumulator.sv
// Accumulates scaled partial sums into one signed result per tile and hands it off on a valid/ready port.
// Optional saturation of the accumulator is enabled by defining VSQ_ACC_SAT_EN.
module vsq_psum_accumulator #(
  parameter int unsigned PSUM_W  = 24,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned NUM_VEC = 16,
  localparam int unsigned CNT_W  = $clog2(NUM_VEC + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PSUM_W-1:0] in_psum,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_sat
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic signed [ACC_W-1:0] acc_q;
  logic        [CNT_W-1:0] count_q;

  logic                    accept_c;
  logic                    handshake_c;
  logic                    close_c;
  logic        [CNT_W-1:0] count_inc_c;
  logic signed [ACC_W-1:0] acc_base_c;
  logic signed [ACC_W-1:0] psum_ext_c;
  logic signed [ACC_W-1:0] acc_new_c;
  logic                    sat_new_c;

  // First beat of a tile starts from zero regardless of leftover accumulator contents
  assign count_inc_c = count_q + CNT_W'(1);
  assign close_c     = in_last || (count_inc_c == CNT_W'(NUM_VEC));
  assign acc_base_c  = (count_q == '0) ? '0 : acc_q;
  assign psum_ext_c  = ACC_W'(signed'(in_psum));

`ifdef VSQ_ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic                  sat_q;
  logic signed [ACC_W:0] sum_c;
  logic                  ovf_c;

  // One guard bit exposes overflow; the sign of the wide sum picks the clamp rail
  assign sum_c     = (ACC_W+1)'(acc_base_c) + (ACC_W+1)'(psum_ext_c);
  assign ovf_c     = sum_c[ACC_W] ^ sum_c[ACC_W-1];
  assign acc_new_c = ovf_c ? (sum_c[ACC_W] ? ACC_MIN : ACC_MAX) : sum_c[ACC_W-1:0];
  assign sat_new_c = ((count_q != '0) && sat_q) || ovf_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (accept_c) begin
      sat_q <= sat_new_c;
    end
  end
`else
  assign acc_new_c = acc_base_c + psum_ext_c;
  assign sat_new_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake decode
  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    accept_c    = 1'b0;
    handshake_c = 1'b0;
    case (state_q)
      S_IDLE, S_ACC: begin
        in_ready = !rst;
        accept_c = in_valid && !rst;
        if (accept_c) begin
          state_d = close_c ? S_OUT : S_ACC;
        end
      end
      S_OUT: begin
        handshake_c = out_valid && out_ready;
        if (handshake_c) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Accumulator, beat counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      count_q   <= '0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_cnt   <= '0;
      out_sat   <= 1'b0;
    end else if (accept_c) begin
      acc_q   <= acc_new_c;
      count_q <= count_inc_c;
      if (close_c) begin
        out_valid <= 1'b1;
        out_acc   <= acc_new_c;
        out_cnt   <= count_inc_c;
        out_sat   <= sat_new_c;
      end
    end else if (handshake_c) begin
      out_valid <= 1'b0;
      acc_q     <= '0;
      count_q   <= '0;
    end
  end

endmodule
